// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main sequencing FSM for the multicycle MIPS datapath
// Moore-decoded control with mem_ready wait states; FETCH and DECODE carry input-dependent outputs.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       illegal_op,
    output logic [3:0] state_out
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [3:0] state;
    logic [3:0] state_next;
    logic       op_is_mem;
    logic       op_known;

    // Reset is asynchronous so a write in flight is cut off without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign op_is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    assign op_known  = op_is_mem || (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                       (opcode == OP_ADDI) || (opcode == OP_J);

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op_is_mem) begin
                    state_next = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_next = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (opcode == OP_ADDI) begin
                    state_next = S_ADDIEX;
                end else if (opcode == OP_J) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALU_ADD;
        PCSrc      = PC_ALU;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                // IR and PC only latch on the cycle the fetch actually completes.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                illegal_op = !op_known;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_SUB;
                PCSrc   = PC_ALUOUT;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PC_JUMP;
                PCWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
// Stimulus plans whole instructions and queues per-cycle expectations; a negedge monitor checks them.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, Branch, illegal_op;
    logic [3:0] state_out;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    logic [20:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .illegal_op(illegal_op), .state_out(state_out)
    );

    // Expected control word for a state, written straight from the per-state output list.
    function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit ill);
        bit iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
        bit pcw = 0, br = 0, il = 0;
        bit [1:0] asb = 0, aop = 0, pcs = 0;
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin asb = 2'b11; il = ill; end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin iord = 1; mr = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin iord = 1; mw = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rd = 1; rw = 1; end
            9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            12: begin pcs = 2'b10; pcw = 1; end
            default: begin end
        endcase
        return {iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcw, br, il};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h08 || op == 6'h02;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input int st, input bit rdy, input logic [5:0] opc, input bit ill);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        opcode = opc;
        exp_q.push_back({4'(st), exp_out(st, rdy, ill)});
    endtask

    // Opcode is only meaningful in DECODE and MEMADR; elsewhere it is deliberately scrambled.
    task automatic run_instr(input logic [5:0] opc, input int wf, input int wm);
        bit ill;
        ill = !is_legal(opc);
        for (int i = 0; i < wf; i++) cyc(1, 0, rop(), 0);
        cyc(1, 1, rop(), 0);
        cyc(2, rb(), opc, ill);
        if (ill) return;
        case (opc)
            6'h23: begin
                cyc(3, rb(), opc, 0);
                for (int i = 0; i < wm; i++) cyc(4, 0, rop(), 0);
                cyc(4, 1, rop(), 0);
                cyc(5, rb(), rop(), 0);
            end
            6'h2B: begin
                cyc(3, rb(), opc, 0);
                for (int i = 0; i < wm; i++) cyc(6, 0, rop(), 0);
                cyc(6, 1, rop(), 0);
            end
            6'h00: begin cyc(7, rb(), rop(), 0); cyc(8, rb(), rop(), 0); end
            6'h04: cyc(9, rb(), rop(), 0);
            6'h08: begin cyc(10, rb(), rop(), 0); cyc(11, rb(), rop(), 0); end
            default: cyc(12, rb(), rop(), 0);
        endcase
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ready = 1'b1;
        exp_q.push_back({4'd0, 17'd0});
    endtask

    // Monitor: every queued expectation is matched against the DUT at the falling edge.
    always @(negedge clk) begin
        logic [20:0] e;
        logic [20:0] a;
        cyc_n++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_out, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, illegal_op};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d ctrl: state got=%0d exp=%0d outs got=%h exp=%h",
                         cyc_n, a[20:17], e[20:17], a[16:0], e[16:0]);
            end
            total++;
            if ((MemRead && MemWrite) || (RegWrite && (MemWrite || PCWrite)) ||
                (PCWrite && Branch)) begin
                bad++;
                $display("FAIL cycle%0d invariant: mr=%b mw=%b rw=%b pcw=%b br=%b exp=exclusive",
                         cyc_n, MemRead, MemWrite, RegWrite, PCWrite, Branch);
            end
        end
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] o;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h08; ops[5] = 6'h02; ops[6] = 6'h3F;

        for (int i = 0; i < 3; i++) cyc(0, 1, rop(), 0);
        release_reset();

        run_instr(6'h23, 0, 0);
        run_instr(6'h2B, 0, 2);
        run_instr(6'h00, 0, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h23, 2, 1);

        // Reset lands mid-cycle during a stalled MEMRD.
        cyc(1, 1, rop(), 0);
        cyc(2, 1, 6'h23, 0);
        cyc(3, 1, 6'h23, 0);
        cyc(4, 0, rop(), 0);
        @(posedge clk);
        #1;
        exp_q.push_back({4'd0, 17'd0});
        #1;
        reset = 1'b0;
        cyc(0, 1, rop(), 0);
        cyc(0, 0, rop(), 0);
        release_reset();

        for (int n = 0; n < 70; n++) begin
            o = ops[$urandom_range(0, 6)];
            if (o == 6'h3F) begin
                do o = rop(); while (is_legal(o));
            end
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory access and write-back for the supported opcodes, and drives every datapath mux select and write enable. Instruction fetch and data accesses share one memory through a ready handshake, so the block inserts wait cycles when memory is slow. The opcode input comes from the instruction register. It is valid from DECODE onward and holds stable until the next IRWrite.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word
OP_SW, 6'h2B, store word
OP_BEQ, 6'h04, branch equal
OP_ADDI, 6'h08, add immediate
OP_J, 6'h02, jump

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] from the instruction register
mem_ready  in  1  memory completes the current access this cycle
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load the instruction register
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=MDR
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
ALUOp  out  2  00=add, 01=sub, 10=use funct
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
PCWrite  out  1  unconditional PC write
Branch  out  1  conditional PC write, ANDed with Zero in the datapath
illegal_op  out  1  one-cycle pulse: unsupported opcode seen in DECODE
state_out  out  4  current state encoding, for debug

Behaviour:
- One state register, 4 bits. Encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- Reset low: state goes to IDLE immediately, regardless of clk. This includes reset asserted mid-instruction; no partial write completes after reset asserts.
- Outputs are Moore-decoded combinationally from state. Exceptions: FETCH IRWrite/PCWrite, and DECODE illegal_op. Any output not listed for a state is 0. In IDLE every output is 0 and state_out=0.
- Unused encodings 13-15: all outputs 0, next state IDLE.
- IDLE: next state FETCH unconditionally. The first fetch therefore happens on the 2nd clock after reset release.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP. Any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD if opcode=LW, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until mem_ready=1, then FETCH. MemWrite stays asserted through the wait.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- Cycle counts with mem_ready held at 1: LW=5, SW=4, RTYPE=4, ADDI=4, BEQ=3, J=3, illegal=2. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- Invariants:
  - MemRead and MemWrite never assert together.
  - RegWrite never asserts in the same cycle as MemWrite or PCWrite.
  - At most one of PCWrite and Branch is 1 in any cycle.
- opcode changes outside DECODE and MEMADR have no effect.

Test Plan:
1. Reset held low 3 cycles, then released with mem_ready=1 → state_out=0 while low. One IDLE cycle after release, then FETCH with MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
2. opcode=6'h23, mem_ready=1 → state sequence 1,2,3,4,5,1. RegWrite=1 and MemtoReg=1 only in state 5. IorD=1 only in state 4.
3. opcode=6'h2B, mem_ready low for 2 cycles in MEMWR → states 1,2,3,6,6,6,1. MemWrite=1 for 3 consecutive cycles. RegWrite stays 0 throughout.
4. Sequence RTYPE, ADDI, BEQ, J back-to-back → lengths 4, 4, 3, 3 cycles. ALUOp=10 only in EXEC. Branch=1 with PCSrc=01 in BRANCH. PCWrite=1 with PCSrc=10 in JUMP.
5. opcode=6'h3F → illegal_op=1 for exactly one cycle, in DECODE. Next state FETCH. No RegWrite or MemWrite is issued.
6. Reset asserted asynchronously mid-cycle during MEMRD → state_out=0 and all outputs 0 before the next clk edge. Normal fetch resumes after release.
